// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target state encoding, bus widths and ACK/NACK levels.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;
  localparam int unsigned I2C_CNT_W  = 4;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_target_line_sync.sv
// Two-flop synchronizer for one bus line plus combinational rise/fall pulses.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Reset to the idle-high bus level so reset itself never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], din};
      prev_q <= sync_q[1];
    end
  end

  assign level  = sync_q[1];
  assign rise_c = sync_q[1] & ~prev_q;
  assign fall_c = ~sync_q[1] & prev_q;

endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target: START/STOP detection, address ACK, byte-wide
// write receive and read transmit with open-drain SDA and no clock stretching.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic                  tx_req,
  output logic                  busy
);

  localparam logic [I2C_CNT_W-1:0] CNT_FULL = I2C_CNT_W'(I2C_BYTE_W);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start, stop;

  i2c_line_sync u_scl_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (scl_in),
    .level  (scl),
    .rise_c (scl_rise),
    .fall_c (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (sda_in),
    .level  (sda),
    .rise_c (sda_rise),
    .fall_c (sda_fall)
  );

  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  i2c_tgt_state_t             state_q, state_d;
  logic [I2C_CNT_W-1:0]       bit_cnt_q, bit_cnt_d, cnt_inc;
  logic [I2C_BYTE_W-1:0]      shift_q, shift_d, shift_in;
  logic                       rw_q, rw_d;
  logic                       sda_oe_d, rx_valid_d, tx_req_d, busy_d;
  logic [I2C_BYTE_W-1:0]      rx_data_d;

  assign shift_in = {shift_q[I2C_BYTE_W-2:0], sda};
  assign cnt_inc  = (bit_cnt_q >= CNT_FULL) ? CNT_FULL : I2C_CNT_W'(bit_cnt_q + 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      sda_oe    <= sda_oe_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      tx_req    <= tx_req_d;
      busy      <= busy_d;
    end
  end

  // Bus conditions first; otherwise SCL edges advance the per-state bit protocol.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy;

    if (start) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = cnt_inc;
            if (cnt_inc == CNT_FULL) begin
              if (shift_in[I2C_BYTE_W-1:1] == TARGET_ADDR) begin
                state_d = ADDR_ACK;
                rw_d    = shift_in[0];
                busy_d  = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        ADDR_ACK, WR_ACK: begin
          // sda_oe doubles as the phase flag: low before the ACK slot, high within it.
          if (scl_rise && state_q == ADDR_ACK && rw_q) begin
            tx_req_d = 1'b1;
          end
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else if (state_q == ADDR_ACK && rw_q) begin
              state_d   = RD_BYTE;
              sda_oe_d  = ~tx_data[I2C_BYTE_W-1];
              shift_d   = {tx_data[I2C_BYTE_W-2:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = WR_BYTE;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = cnt_inc;
            if (cnt_inc == CNT_FULL) begin
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              state_d    = WR_ACK;
              sda_oe_d   = 1'b0;
            end
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q >= CNT_FULL) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              sda_oe_d  = ~shift_q[I2C_BYTE_W-1];
              shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
              bit_cnt_d = cnt_inc;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda == I2C_ACK) begin
              tx_req_d = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall) begin
            state_d   = RD_BYTE;
            sda_oe_d  = ~tx_data[I2C_BYTE_W-1];
            shift_d   = {tx_data[I2C_BYTE_W-2:0], 1'b0};
            bit_cnt_d = 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench: bit-banged I2C initiator on a wired-AND bus against i2c_target.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic       scl_in, sda_in, sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;

  int checks = 0;
  int errors = 0;
  int rv_cnt = 0, txr_cnt = 0, oe_cnt = 0, busy_cnt = 0;

  assign scl_in = m_scl;
  assign sda_in = ~(m_sda_low | sda_oe);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid) rv_cnt   <= rv_cnt + 1;
    if (tx_req)   txr_cnt  <= txr_cnt + 1;
    if (sda_oe)   oe_cnt   <= oe_cnt + 1;
    if (busy)     busy_cnt <= busy_cnt + 1;
  end

  i2c_target #(.TARGET_ADDR(7'h50)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic sampled);
    m_sda_low = ~b;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    sampled = sda_in;
    wait_clks(Q);
    m_scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    m_sda_low = 1'b1;
    wait_clks(Q);
    m_scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    m_sda_low = 1'b0;
    wait_clks(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_sda);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack_sda);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(nack, s);
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    int         base_rv, base_txr, base_oe, base_busy;

    wait_clks(4);
    rst = 1'b0;
    wait_clks(4);
    check("reset_sda_oe",   32'(sda_oe),   32'h0);
    check("reset_rx_data",  32'(rx_data),  32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_tx_req",   32'(tx_req),   32'h0);
    check("reset_busy",     32'(busy),     32'h0);

    // Write 0xA5 to 0x50
    base_rv = rv_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    check("w1_addr_ack", 32'(ack), 32'h0);
    check("w1_busy", 32'(busy), 32'h1);
    write_byte(8'hA5, ack);
    check("w1_data_ack", 32'(ack), 32'h0);
    check("w1_rx_data", 32'(rx_data), 32'hA5);
    bus_stop();
    check("w1_busy_after_stop", 32'(busy), 32'h0);
    check("w1_rx_valid_pulses", 32'(rv_cnt - base_rv), 32'd1);

    // Write to 0x51: ignored
    base_rv = rv_cnt; base_oe = oe_cnt; base_busy = busy_cnt;
    bus_start();
    write_byte(8'hA2, ack);
    check("w2_addr_nack", 32'(ack), 32'h1);
    write_byte(8'h55, ack);
    bus_stop();
    check("w2_no_sda_oe", 32'(oe_cnt - base_oe), 32'd0);
    check("w2_no_rx_valid", 32'(rv_cnt - base_rv), 32'd0);
    check("w2_no_busy", 32'(busy_cnt - base_busy), 32'd0);

    // Read two bytes from 0x50, ACK then NACK
    base_txr = txr_cnt;
    tx_data = 8'h3C;
    bus_start();
    write_byte(8'hA1, ack);
    check("r1_addr_ack", 32'(ack), 32'h0);
    tx_data = 8'hF0;
    read_byte(I2C_ACK, d);
    check("r1_byte0", 32'(d), 32'h3C);
    read_byte(I2C_NACK, d);
    check("r1_byte1", 32'(d), 32'hF0);
    check("r1_tx_req_pulses", 32'(txr_cnt - base_txr), 32'd2);
    check("r1_sda_released", 32'(sda_oe), 32'h0);
    check("r1_busy_after_nack", 32'(busy), 32'h0);
    bus_stop();

    // Repeated START mid write byte, then read
    base_rv = rv_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    check("rs_addr_w_ack", 32'(ack), 32'h0);
    for (int i = 0; i < 4; i++) clock_bit(i[0], s);
    tx_data = 8'h96;
    bus_start();
    write_byte(8'hA1, ack);
    check("rs_addr_r_ack", 32'(ack), 32'h0);
    read_byte(I2C_NACK, d);
    check("rs_read_byte", 32'(d), 32'h96);
    bus_stop();
    check("rs_no_rx_valid", 32'(rv_cnt - base_rv), 32'd0);

    // STOP after 5 data bits
    base_rv = rv_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    for (int i = 0; i < 5; i++) clock_bit(1'b1, s);
    bus_stop();
    check("ps_no_rx_valid", 32'(rv_cnt - base_rv), 32'd0);
    check("ps_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("ps_sda_oe", 32'(sda_oe), 32'h0);

    // Async reset during an ACK slot, then a clean write
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(i == 0 ? 1'b0 : ((8'hA0 >> i) & 8'h1) != 0, s);
    m_sda_low = 1'b0;
    check("ar_oe_in_ack", 32'(sda_oe), 32'h1);
    #1 rst = 1'b1;
    #1 check("ar_oe_async_drop", 32'(sda_oe), 32'h0);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
    bus_start();
    write_byte(8'hA0, ack);
    check("ar_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h12, ack);
    check("ar_data_ack", 32'(ack), 32'h0);
    bus_stop();
    check("ar_rx_data", 32'(rx_data), 32'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) for a single 7-bit address. It works with the team's I2C initiator on the same two-wire bus. It oversamples SCL/SDA on the system clock, detects START/STOP, matches the address and ACKs it, then receives write bytes or transmits read bytes through a simple byte-wide user handshake. SDA is driven open-drain via an output-enable only; SCL is never driven, so there is no clock stretching.

## Interface
- `TARGET_ADDR`, default 7'h50: 7-bit address this target responds to.
- `clk` input 1: system clock, must be ≥ 16× SCL frequency.
- `rst` input 1: asynchronous, active-high reset.
- `scl_in` input 1: raw SCL from pad, asynchronous.
- `sda_in` input 1: raw SDA from pad, asynchronous.
- `sda_oe` output 1: 1 pulls SDA low, 0 releases it; pad ties the output data to 0.
- `rx_data` output 8: last byte received in a write transfer; held until the next byte.
- `rx_valid` output 1: 1-cycle pulse when `rx_data` updates.
- `tx_data` input 8: next byte to send in a read transfer.
- `tx_req` output 1: 1-cycle pulse requesting `tx_data` for the next read byte.
- `busy` output 1: high from address match until STOP, next START or NACK end.
- Reset values: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0, state IDLE.

## Operation
- SCL and SDA each pass through a 2-FF synchronizer, then a 1-FF edge detector. All decisions use the synchronized values.
- START: SDA falls while SCL is high. Recognized in any state, including mid-byte (repeated START). Go to ADDR, bit counter = 0, release `sda_oe`.
- STOP: SDA rises while SCL is high. Recognized in any state. Go to IDLE, release `sda_oe`, clear `busy`, discard any partial byte with no `rx_valid`.
- Bits are sampled MSB-first on the SCL rising edge. The target changes `sda_oe` only on the SCL falling edge.
- ADDR: shift 8 bits (7 address bits + R/W).
  - On match: go to ADDR_ACK and assert `busy`.
  - On mismatch: go to IDLE; `sda_oe` is never asserted until the next START.
- ADDR_ACK: `sda_oe`=1 from the falling edge after bit 8 until the falling edge after the 9th clock.
  - If R/W=0: go to WR_BYTE.
  - If R/W=1: pulse `tx_req` on the 9th rising edge, latch `tx_data` on the 9th falling edge, go to RD_BYTE.
- WR_BYTE: shift 8 bits. On the 8th rising edge, `rx_data` ← byte and pulse `rx_valid`. Go to WR_ACK.
- WR_ACK: drive ACK exactly as in ADDR_ACK, then return to WR_BYTE.
- RD_BYTE: drive `sda_oe` = ~shift[7] at each falling edge, starting with the latching falling edge, then shift left. After the 8th bit's falling edge, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on the 9th rising edge.
  - ACK (0): pulse `tx_req`, latch `tx_data` on the falling edge, go to RD_BYTE.
  - NACK (1): go to IDLE with SDA released and `busy` cleared, then wait for STOP or START.
- States (enum): IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.

## Timing
- Input-to-decision latency: 3 clk (2 sync + 1 edge register). `sda_oe` changes on the clk after the detected falling edge.
- `rx_valid` asserts 1 clk after the synchronized 8th SCL rising edge of a write byte.
- `tx_req` asserts 1 clk after the synchronized 9th SCL rising edge. The user must present `tx_data` within the SCL high phase (≥ 7 clk at minimum ratio).
- START/STOP have priority over any data-bit event detected in the same cycle.
- SDA edges while SCL is low are data changes, never START/STOP.
- Bit counter is 4 bits and saturates at 8; no wrap-around.
- Async `rst` mid-transfer: `sda_oe` drops to 0 immediately (the bus is released). After reset, the next START is still detected; the transfer in flight is ignored.

## Structure
- Package `i2c_pkg` holds:
  - the state enum `i2c_tgt_state_t`;
  - constant `I2C_ADDR_W`=7;
  - constant `I2C_BYTE_W`=8;
  - ACK/NACK constants, shared with the initiator.
- Sub-module `i2c_line_sync`: 2-FF synchronizer plus rise/fall pulse outputs, instantiated once for SCL and once for SDA.

## Test plan
- Write to 0x50, data 0xA5, then STOP → `sda_oe`=1 in both ACK slots; `rx_data`=0xA5 with exactly one `rx_valid` pulse; `busy` 1→0 at STOP.
- Address 0x51 write → `sda_oe` stays 0 for the whole transfer; no `rx_valid`; `busy` stays 0.
- Read from 0x50 with `tx_data`=0x3C, master ACK, then `tx_data`=0xF0, master NACK → SDA bits 00111100 then 11110000; two `tx_req` pulses; SDA released after NACK.
- Repeated START after 4 bits of a write byte, then address 0x50 R → no `rx_valid`; new read proceeds with ACK.
- STOP after 5 data bits → no `rx_valid`; state IDLE; `sda_oe`=0.
- Assert `rst` while `sda_oe`=1 in an ACK slot → `sda_oe`=0 asynchronously; following write to 0x50 of 0x12 yields `rx_data`=0x12.
